key_debounce: RTL



---
 rtl/key_pkg.sv | 15 +
 rtl/key_filter.sv | 147 ++++++++++++++
 rtl/key_debounce.sv | 60 ++++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared types and 50 MHz default timing constants for the key debouncer.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        HELD       = 2'd2,
        REL_FILT   = 2'd3
    } key_fsm_t;

    localparam int   KEY_DEBOUNCE_CYC = 1000000;   // 20 ms at 50 MHz
    localparam int   KEY_LONG_CYC     = 50000000;  // 1 s at 50 MHz
    localparam logic KEY_RELEASED     = 1'b1;

endpackage

// File: rtl/key_filter.sv
// One key: two-flop synchroniser, debounce FSM, press/release pulses and,
// when KEY_LONG_PRESS_EN is defined, a long-press hold counter.
module key_filter
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = KEY_DEBOUNCE_CYC,
    parameter int CNT_W        = 20,
    parameter int LONG_CYC     = KEY_LONG_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic held,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic press_next
);

    if (DEBOUNCE_CYC < 1 || 64'(DEBOUNCE_CYC) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
        $error("key_filter: CNT_W too narrow for DEBOUNCE_CYC");
    end
    if (LONG_CYC < 1) begin : g_bad_long
        $error("key_filter: LONG_CYC must be positive");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1, sync2;
    logic             s_pressed;
    key_fsm_t         state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             release_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= KEY_RELEASED;
            sync2 <= KEY_RELEASED;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
        end
    end

    assign s_pressed = (sync2 != KEY_RELEASED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            press_pulse   <= press_next;
            release_pulse <= release_nxt;
        end
    end

    // A bounce inside either filter window restarts from the stable side.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        press_next  = 1'b0;
        release_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (s_pressed) begin
                    state_nxt = PRESS_FILT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            PRESS_FILT: begin
                if (!s_pressed) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt  = HELD;
                    cnt_nxt    = '0;
                    press_next = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!s_pressed) begin
                    state_nxt = REL_FILT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            REL_FILT: begin
                if (s_pressed) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = IDLE;
                    cnt_nxt     = '0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign held = (state == HELD) || (state == REL_FILT);

`ifdef KEY_LONG_PRESS_EN
    localparam int                LONG_W    = $clog2(LONG_CYC + 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);
    localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(1);

    logic [LONG_W-1:0] hold_cnt;
    logic              long_done;

    // Counts every held-low sample, including a bounce back from REL_FILT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt   <= '0;
            long_done  <= 1'b0;
            long_pulse <= 1'b0;
        end else begin
            long_pulse <= 1'b0;
            if (press_next) begin
                hold_cnt  <= '0;
                long_done <= 1'b0;
            end else if (held && s_pressed && !long_done) begin
                if (hold_cnt == LONG_LAST) begin
                    long_pulse <= 1'b1;
                    long_done  <= 1'b1;
                end else begin
                    hold_cnt <= hold_cnt + LONG_ONE;
                end
            end
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer with press/release pulses and lowest-index key encoder.
// Long-press detection is built only when KEY_LONG_PRESS_EN is defined.
module key_debounce
    import key_pkg::*;
#(
    parameter int KEY_W        = 4,
    parameter int DEBOUNCE_CYC = KEY_DEBOUNCE_CYC,
    parameter int CNT_W        = 20,
    parameter int LONG_CYC     = KEY_LONG_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key,
    output logic [KEY_W-1:0] key_state,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release,
    output logic             key_valid,
    output logic [1:0]       key_code,
    output logic [KEY_W-1:0] key_long
);

    logic [KEY_W-1:0] press_next;
    logic [1:0]       code_next;

    for (genvar g = 0; g < KEY_W; g++) begin : g_key
        key_filter #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .CNT_W       (CNT_W),
            .LONG_CYC    (LONG_CYC)
        ) u_filter (
            .clk          (clk),
            .rst_n        (rst_n),
            .key          (key[g]),
            .held         (key_state[g]),
            .press_pulse  (key_press[g]),
            .release_pulse(key_release[g]),
            .long_pulse   (key_long[g]),
            .press_next   (press_next[g])
        );
    end

    // Encoded from the filters' next-cycle press so it lines up with key_press.
    always_comb begin
        code_next = 2'd0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (press_next[i]) code_next = 2'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid <= 1'b0;
            key_code  <= 2'd0;
        end else begin
            key_valid <= |press_next;
            key_code  <= code_next;
        end
    end

endmodule
